// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and shared memory.
//   master : arbiter view (takes requests, drives acks/rdata and memory commands)
//   slave  : environment view (requesters plus memory)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    // data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // shared memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_rnw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wmask,
        output d_ack, d_rdata,
        output mem_req_valid, mem_rnw, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wmask,
        input  d_ack, d_rdata,
        input  mem_req_valid, mem_rnw, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory, one transaction
// in flight. Alternates grants on a tie, starting with data after reset.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.master (requester ports and memory command/response)
//   busy : high whenever the FSM is not idle
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          busy
);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t state;
    logic   grant_data;   // current transaction belongs to the data port
    logic   last_grant;   // 1 = data was granted last, 0 = fetch
    logic   pick_data_c;

    // Data wins when alone, or on a tie when fetch was granted last.
    assign pick_data_c = bus.d_req && (!bus.i_req || !last_grant);

    // Control FSM; the mem_* outputs double as the latched command register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            grant_data        <= 1'b0;
            last_grant        <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_rnw       <= 1'b0;
            bus.mem_addr      <= ADDR_W'(0);
            bus.mem_wdata     <= DATA_W'(0);
            bus.mem_wmask     <= MASK_W'(0);
            bus.i_ack         <= 1'b0;
            bus.d_ack         <= 1'b0;
            bus.i_rdata       <= DATA_W'(0);
            bus.d_rdata       <= DATA_W'(0);
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        state             <= ISSUE;
                        busy              <= 1'b1;
                        bus.mem_req_valid <= 1'b1;
                        grant_data        <= pick_data_c;
                        last_grant        <= pick_data_c;
                        if (pick_data_c) begin
                            bus.mem_rnw   <= ~bus.d_we;
                            bus.mem_addr  <= ADDR_W'(bus.d_addr);
                            bus.mem_wdata <= DATA_W'(bus.d_wdata);
                            bus.mem_wmask <= MASK_W'(bus.d_wmask);
                        end else begin
                            bus.mem_rnw   <= 1'b1;
                            bus.mem_addr  <= ADDR_W'(bus.i_addr);
                            bus.mem_wdata <= DATA_W'(0);
                            bus.mem_wmask <= MASK_W'(0);
                        end
                    end
                end
                ISSUE: begin
                    // A response during the handshake cycle is not ours yet.
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state <= ACK;
                        if (grant_data) begin
                            bus.d_ack <= 1'b1;
                            if (bus.mem_rnw) begin
                                bus.d_rdata <= DATA_W'(bus.mem_rdata);
                            end
                        end else begin
                            bus.i_ack   <= 1'b1;
                            bus.i_rdata <= DATA_W'(bus.mem_rdata);
                        end
                    end
                end
                ACK: begin
                    // Ack pulse is visible during this state; no arbitration here.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch latency, tie alternation,
// write backpressure, stray responses and reset mid-transaction.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   total  = 0;
    int   passed = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Memory side of one transaction: wait for valid, stall, handshake,
    // respond next cycle, report which port acked and drop its request.
    task automatic serve(input int stall, input logic [31:0] rd,
                         output logic [31:0] addr, output logic rnw, output int who);
        int n = 0;
        who  = 0;
        addr = '0;
        rnw  = 1'b0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.mem_req_valid) begin
            check("req_timeout", 64'(bus.mem_req_valid), 64'd1);
            return;
        end
        addr = bus.mem_addr;
        rnw  = bus.mem_rnw;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rd;
        tick();
        bus.mem_resp_valid = 1'b0;
        if (bus.i_ack) begin who = 1; bus.i_req = 1'b0; end
        if (bus.d_ack) begin who = who + 2; bus.d_req = 1'b0; end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic        rnw;
        int          who;
        logic [31:0] rd;

        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;

        // Reset state
        tick();
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_acks",  64'({bus.i_ack, bus.d_ack}), 64'd0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
        check("rst_cmd",   64'({bus.mem_rnw, bus.mem_addr}), 64'd0);
        do_reset();

        // Fetch only, minimum latency: ack in cycle 3
        bus.i_req = 1; bus.i_addr = 32'h100; bus.mem_req_ready = 1;
        tick();
        check("f_valid", 64'({bus.mem_req_valid, bus.mem_rnw, busy}), 64'h7);
        check("f_addr",  64'(bus.mem_addr), 64'h100);
        check("f_wzero", 64'({bus.mem_wdata, bus.mem_wmask}), 64'd0);
        tick();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hDEADBEEF;
        check("f_c2_noack", 64'({bus.i_ack, bus.mem_req_valid}), 64'd0);
        tick();
        check("f_c3_ack", 64'({bus.i_ack, bus.d_ack}), 64'h2);
        check("f_rdata",  64'(bus.i_rdata), 64'hDEADBEEF);
        bus.mem_resp_valid = 0; bus.i_req = 0;
        tick();
        check("f_done", 64'({bus.i_ack, busy}), 64'd0);

        // Tie after reset: D, I, D, I
        do_reset();
        bus.i_addr = 32'h300; bus.d_addr = 32'h200; bus.d_we = 0;
        for (int k = 0; k < 4; k++) begin
            bus.i_req = 1; bus.d_req = 1;
            rd = 32'hA000_0000 + 32'(k);
            serve(0, rd, addr, rnw, who);
            check($sformatf("tie%0d_who", k), 64'(who), (k % 2 == 0) ? 64'd2 : 64'd1);
            check($sformatf("tie%0d_cmd", k), 64'({rnw, addr}),
                  (k % 2 == 0) ? 64'h1_0000_0200 : 64'h1_0000_0300);
            check($sformatf("tie%0d_rdata", k),
                  64'((k % 2 == 0) ? bus.d_rdata : bus.i_rdata), 64'(rd));
        end
        bus.i_req = 0; bus.d_req = 0;

        // Write with 4 cycles of backpressure; later input changes ignored
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'hCAFEF00D; bus.d_wmask = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.d_addr  = 32'h44 + 32'(i);
            bus.d_wdata = 32'h1111_0000 + 32'(i);
            bus.d_wmask = 4'h1;
            bus.d_we    = 0;
            check($sformatf("bp%0d_ctl", i), 64'({bus.mem_req_valid, bus.mem_rnw, bus.mem_wmask}), 64'h2F);
            check($sformatf("bp%0d_addr", i), 64'(bus.mem_addr), 64'h40);
            check($sformatf("bp%0d_wdata", i), 64'(bus.mem_wdata), 64'hCAFEF00D);
            tick();
        end
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_resp_valid = 0;
        check("wr_ack",   64'({bus.d_ack, bus.i_ack}), 64'h2);
        check("wr_rdata", 64'(bus.d_rdata), 64'hA0000002);
        bus.d_req = 0;
        tick();
        check("wr_done", 64'({bus.d_ack, busy}), 64'd0);

        // Stray responses in IDLE, ISSUE and on the handshake cycle
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        check("sx_idle_ack", 64'({bus.i_ack, bus.d_ack, busy}), 64'd0);
        check("sx_idle_rd",  {bus.i_rdata, bus.d_rdata}, 64'hA0000003_A0000002);
        bus.mem_resp_valid = 0;
        bus.i_req = 1; bus.i_addr = 32'h500;
        tick();
        bus.mem_resp_valid = 1;
        tick();
        check("sx_issue", 64'({bus.i_ack, bus.d_ack, bus.mem_req_valid}), 64'd1);
        bus.mem_req_ready = 1;
        tick();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
        check("sx_hs_ack", 64'({bus.i_ack, busy}), 64'd1);
        check("sx_hs_rd",  64'(bus.i_rdata), 64'hA0000003);
        tick();
        check("sx_wait", 64'({bus.i_ack, busy}), 64'd1);
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h5555AAAA;
        tick();
        bus.mem_resp_valid = 0;
        check("sx_real_ack", 64'({bus.i_ack, bus.d_ack}), 64'h2);
        check("sx_real_rd",  64'(bus.i_rdata), 64'h5555AAAA);
        bus.i_req = 0;
        tick();

        // Reset while waiting for the response
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60; bus.mem_req_ready = 1;
        tick();
        tick();
        bus.mem_req_ready = 0;
        check("rw_inwait", 64'({busy, bus.mem_req_valid}), 64'h2);
        rst = 1;
        #1;
        check("rw_busy",  64'({busy, bus.mem_req_valid, bus.d_ack, bus.i_ack}), 64'd0);
        check("rw_regs",  {bus.i_rdata, bus.d_rdata}, 64'd0);
        check("rw_cmd",   64'({bus.mem_rnw, bus.mem_addr}), 64'd0);
        #2;
        rst = 0; bus.d_req = 0;
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h77777777;
        tick();
        bus.mem_resp_valid = 0;
        check("rw_stale", 64'({bus.d_ack, bus.i_ack, busy}), 64'd0);
        tick();
        check("rw_after", 64'({bus.d_ack, bus.i_ack}), 64'd0);
        check("rw_rd",    64'(bus.d_rdata), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width; byte-mask width is DATA_W/8.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request; held with i_addr until i_ack.
REQ-006 i_addr  input  ADDR_W  fetch address.
REQ-007 i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  output  DATA_W  registered fetch data.
REQ-009 d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_wmask until d_ack.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  write data.
REQ-013 d_wmask  input  DATA_W/8  byte write enables.
REQ-014 d_ack  output  1  one-cycle pulse: data access complete.
REQ-015 d_rdata  output  DATA_W  registered read data.
REQ-016 mem_req_valid  output  1  command valid to shared memory.
REQ-017 mem_req_ready  input  1  memory accepts command when valid && ready.
REQ-018 mem_rnw  output  1  1 = read, 0 = write.
REQ-019 mem_addr / mem_wdata / mem_wmask  output  ADDR_W / DATA_W / DATA_W/8  command fields.
REQ-020 mem_resp_valid  input  1  one-cycle response pulse (reads and writes).
REQ-021 mem_rdata  input  DATA_W  response data, valid with mem_resp_valid.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; one outstanding transaction maximum.
REQ-024 IDLE: any req -> grant, latch command fields into a command register, go ISSUE; no req -> stay.
REQ-025 Grant: single requester wins; both requesting -> grant the port not granted last (last_grant flag, updated on grant).
REQ-026 Fetch command: mem_rnw=1, mem_wdata=0, mem_wmask=0; data command copies d_we inverted, d_addr, d_wdata, d_wmask.
REQ-027 ISSUE: mem_req_valid=1 from command register; fields stable while valid && !ready; valid && ready -> WAIT.
REQ-028 WAIT: mem_resp_valid -> capture mem_rdata into granted port's rdata register (reads only), go ACK; else stay, no timeout.
REQ-029 Writes SHALL leave d_rdata unchanged.
REQ-030 ACK: pulse granted port's ack for exactly one cycle, go IDLE; no grant evaluated in ACK.
REQ-031 mem_resp_valid outside WAIT (including the ISSUE handshake cycle) SHALL be ignored.
REQ-032 Changes to requester inputs after grant SHALL NOT affect the latched command.
REQ-033 Minimum latency: req seen in IDLE at cycle 0, ready at cycle 1, resp at cycle 2 -> ack at cycle 3.
REQ-034 Requester deasserting req before ack is a protocol violation; transaction still completes and acks.

Reset
REQ-035 Reset SHALL force IDLE, last_grant = fetch (so first tie grants data), all outputs 0, rdata/command registers 0.
REQ-036 Reset mid-transaction SHALL abandon it with no ack; later stale mem_resp_valid ignored per REQ-031.

Verification
REQ-037 Fetch only: i_req=1, i_addr=0x100, ready=1, resp next cycle with 0xDEADBEEF -> i_ack at cycle 3, i_rdata=0xDEADBEEF.
REQ-038 Tie after reset: i_req=d_req=1 -> data granted first, fetch second; continued tie alternates D,I,D,I.
REQ-039 Backpressure: ready=0 for 4 cycles with d_we=1, d_addr=0x40, mask=0xF -> mem_* constant, valid held, d_rdata unchanged after d_ack.
REQ-040 Stray response: mem_resp_valid pulsed in IDLE and ISSUE -> no ack, no rdata change.
REQ-041 Reset asserted in WAIT -> outputs 0 immediately, busy=0, subsequent resp produces no ack.
